uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, next generation of the fixed 8N1 receiver.
- Configurable frame: data width, optional even/odd parity, 1 or 2 stop bits.
- Majority-vote bit sampling.
- Per-frame parity, framing and break flags; line-idle re-arm after errors.
- Sits at the serial input of the UART-to-NTT bridge and feeds received words to the command/data unpacker.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per baud period (i_Clock freq / baud); legal range >= 8.
- DATA_BITS, 8, data bits per frame; legal range 5..9; LSB first.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits checked: 1 or 2.

Ports:
- i_Clock, in, 1, sole clock; all logic on rising edge.
- i_Rst_L, in, 1, asynchronous active-low reset.
- i_Rx_Serial, in, 1, asynchronous serial line; idles high.
- o_Rx_DV, out, 1, one-cycle pulse: frame complete; all other outputs valid this cycle.
- o_Rx_Byte, out, DATA_BITS, received data word; bit 0 = first data bit received.
- o_Parity_Err, out, 1, parity mismatch on the frame just completed; always 0 if PARITY_EN=0.
- o_Frame_Err, out, 1, any stop bit sampled 0.
- o_Break, out, 1, every data bit, the parity bit (if present) and the first stop bit sampled 0.

Behaviour:
- Reset (i_Rst_L low, async):
  - Sync flops and 3-bit history set to all 1s.
  - State = IDLE; counters 0.
  - o_Rx_DV = 0, o_Rx_Byte = 0, all error flags = 0.
  - Reset mid-frame abandons the frame; no DV is issued.
- Input path: two-flop synchroniser; synced bit shifts into a 3-entry history every cycle.
  - vote = majority of the 3 history entries.
  - Every "sample" below uses vote.
- Define H = (CLKS_PER_BIT-1)/2 (integer division).
- States: IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_IDLE.
- IDLE:
  - Clear count and bit index; drive o_Rx_DV = 0.
  - Synced line 0 -> START.
- START:
  - Count up to H. At count == H, sample.
  - Sample 0 -> DATA, count = 0. Sample 1 -> IDLE (glitch rejected, no DV).
- DATA:
  - Count 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1, sample into o_Rx_Byte[index] and set count = 0.
  - After the DATA_BITS-th sample: -> PARITY if PARITY_EN, else -> STOP.
  - o_Rx_Byte updates bit by bit during the frame; it is only meaningful while o_Rx_DV = 1.
- PARITY:
  - Same timing as a data bit.
  - o_Parity_Err = (XOR of data bits ^ parity sample ^ PARITY_ODD) != 0.
- STOP:
  - Same timing; STOP_BITS samples taken.
  - Any 0 sample sets o_Frame_Err.
  - o_Break = all data bits 0 AND parity bit 0 (if present) AND first stop sample 0.
  - On the final stop sample: registered o_Rx_DV = 1. Go to CLEANUP if the sample was 1, else WAIT_IDLE.
- Error flags are cleared when a new START is accepted, set during the frame, and held until the next frame.
- CLEANUP: one cycle; o_Rx_DV = 0; -> IDLE.
- WAIT_IDLE:
  - o_Rx_DV = 0.
  - Stays until vote == 1 for 1 cycle, then -> IDLE.
  - No new start is detected while the line is held low (break / line fault).
- Latency:
  - Let edge 0 = first rising edge at which i_Rx_Serial is registered low.
  - o_Rx_DV is high after edge 3 + H + (DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT, for exactly one cycle.
  - Defaults: edge 829.
- Back-to-back frames:
  - Next start bit may begin immediately after the final stop bit.
  - The next start is accepted within 2 cycles of re-entering IDLE; no frame is lost at max line rate.
- Counters:
  - Clock counter width = $clog2(CLKS_PER_BIT); never wraps (compared, then cleared).
  - Bit index width = $clog2(DATA_BITS+1).

Test Plan:
- Defaults, 8N1 frame 0xA5 at 87 clks/bit -> one DV pulse at edge 829; o_Rx_Byte=0xA5; all error flags 0.
- DATA_BITS=7, PARITY_EN=1, PARITY_ODD=0, CLKS_PER_BIT=16: send 0x35 with parity 0 -> DV, byte 0x35, Parity_Err=0. Repeat with parity 1 -> Parity_Err=1, byte 0x35.
- STOP_BITS=2, 0x3C sent with second stop bit 0 -> DV with Frame_Err=1, Break=0. Line then high -> next frame 0x81 received with all flags 0.
- Line held low 30 bit times (defaults) -> exactly one DV: byte 0x00, Frame_Err=1, Break=1. No further DV until the line returns high, and none after.
- Robustness:
  - Start glitch low for H-5 cycles -> no DV.
  - Single-cycle low glitch at the centre of data bit 3 of 0xFF -> byte still 0xFF (majority vote).
- Reset and back-to-back:
  - Assert i_Rst_L low mid-data-bit of 0x55 -> all outputs 0 immediately; no DV for that frame; a clean 0x12 sent after release is received correctly.
  - 16 back-to-back 8N1 frames 0x00..0x0F with no idle gap -> 16 DV pulses, values in order.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS data bits (LSB first), optional even/odd
// parity, 1 or 2 stop bits. A two-flop synchroniser feeds a 3-deep history and
// every bit decision uses the majority vote of that history. Each completed frame
// raises o_Rx_DV for one cycle with the data word and parity/framing/break flags.
// After a frame whose final stop bit reads 0 the receiver waits for the line to
// return high before it looks for another start bit.

module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break
);

  // Sample offset into the start bit; data/parity/stop are then sampled one
  // full baud period apart, landing near the middle of each bit.
  localparam int unsigned HalfBit = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW    = $clog2(DATA_BITS + 1);

  localparam logic [CntW-1:0] CntHalf     = CntW'(HalfBit);
  localparam logic [CntW-1:0] CntLast     = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLastData = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] IdxLastStop = IdxW'(STOP_BITS - 1);
  localparam logic            ParityOdd   = (PARITY_ODD != 0);
  localparam bit              HasParity   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StCleanup,
    StWaitIdle
  } state_e;

  logic [1:0]      sync_q;
  logic [2:0]      hist_q;
  logic            vote;
  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] idx_q;
  // Still 1 while every data bit and the parity bit of this frame read 0.
  logic            zero_q;
  logic            cnt_done;

  // Synchronise the asynchronous line and keep the last three synced samples.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_q <= 2'b11;
      hist_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[0], i_Rx_Serial};
      hist_q <= {hist_q[1:0], sync_q[1]};
    end
  end

  // Majority of the history rejects single-cycle glitches.
  always_comb begin
    vote     = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
    cnt_done = (cnt_q == CntLast);
  end

  // Frame FSM with registered outputs; counters are compared and then cleared.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      zero_q       <= 1'b0;
      o_Rx_DV      <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      o_Rx_DV <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!sync_q[1]) begin
            state_q <= StStart;
          end
        end

        StStart: begin
          if (cnt_q == CntHalf) begin
            cnt_q <= '0;
            if (!vote) begin
              // Start confirmed: flags from the previous frame are dropped here.
              state_q      <= StData;
              zero_q       <= 1'b1;
              o_Parity_Err <= 1'b0;
              o_Frame_Err  <= 1'b0;
              o_Break      <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StData: begin
          if (cnt_done) begin
            cnt_q <= '0;
            for (int unsigned i = 0; i < DATA_BITS; i++) begin
              if (idx_q == IdxW'(i)) begin
                o_Rx_Byte[i] <= vote;
              end
            end
            zero_q <= zero_q & ~vote;
            if (idx_q == IdxLastData) begin
              idx_q   <= '0;
              state_q <= HasParity ? StParity : StStop;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StParity: begin
          if (cnt_done) begin
            cnt_q        <= '0;
            o_Parity_Err <= (^o_Rx_Byte) ^ vote ^ ParityOdd;
            zero_q       <= zero_q & ~vote;
            state_q      <= StStop;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StStop: begin
          if (cnt_done) begin
            cnt_q <= '0;
            if (!vote) begin
              o_Frame_Err <= 1'b1;
            end
            if (idx_q == '0) begin
              o_Break <= zero_q & ~vote;
            end
            if (idx_q == IdxLastStop) begin
              idx_q   <= '0;
              o_Rx_DV <= 1'b1;
              // A low final stop means the line may be stuck; wait for idle.
              state_q <= vote ? StCleanup : StWaitIdle;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StCleanup: begin
          state_q <= StIdle;
        end

        StWaitIdle: begin
          if (vote) begin
            state_q <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg. Three instances cover the default 8N1 setup,
// a 7-bit even-parity setup and a 2-stop-bit setup. Each DV pulse is logged into
// a per-instance queue together with the cycle count; scenario tasks drive the
// line bit by bit and compare the logged frames against hand-computed values.

module tb_uart_rx_cfg;

  localparam int C0 = 87;
  localparam int C1 = 16;
  localparam int C2 = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rx0, rx1, rx2;

  logic       dv0, pe0, fe0, brk0;
  logic [7:0] byte0;
  logic       dv1, pe1, fe1, brk1;
  logic [6:0] byte1;
  logic       dv2, pe2, fe2, brk2;
  logic [7:0] byte2;

  longint cyc = 0;
  ev_t    q0[$];
  ev_t    q1[$];
  ev_t    q2[$];
  longint c0[$];

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(
    .CLKS_PER_BIT(C0), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) u_dut0 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(rx0), .o_Rx_DV(dv0), .o_Rx_Byte(byte0),
    .o_Parity_Err(pe0), .o_Frame_Err(fe0), .o_Break(brk0)
  );

  uart_rx_cfg #(
    .CLKS_PER_BIT(C1), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) u_dut1 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(rx1), .o_Rx_DV(dv1), .o_Rx_Byte(byte1),
    .o_Parity_Err(pe1), .o_Frame_Err(fe1), .o_Break(brk1)
  );

  uart_rx_cfg #(
    .CLKS_PER_BIT(C2), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)
  ) u_dut2 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(rx2), .o_Rx_DV(dv2), .o_Rx_Byte(byte2),
    .o_Parity_Err(pe2), .o_Frame_Err(fe2), .o_Break(brk2)
  );

  // Log every DV pulse, sampled on the falling edge.
  always @(negedge clk) begin
    if (dv0) begin
      q0.push_back({1'b0, byte0, pe0, fe0, brk0});
      c0.push_back(cyc);
    end
    if (dv1) q1.push_back({2'b00, byte1, pe1, fe1, brk1});
    if (dv2) q2.push_back({1'b0, byte2, pe2, fe2, brk2});
  end

  // Hold a line level for n cycles; always returns 1 time unit after a rising edge.
  task automatic drive(input int d, input logic v, input int n);
    case (d)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send8n1(input logic [7:0] data);
    drive(0, 1'b0, C0);
    for (int i = 0; i < 8; i++) drive(0, data[i], C0);
    drive(0, 1'b1, C0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx0 = 1'b1;
    rx1 = 1'b1;
    rx2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if ({dv0, byte0, pe0, fe0, brk0} !== 12'h000) begin
      err_cnt++;
      $display("FAIL reset_dut0: got %h expected 000", {dv0, byte0, pe0, fe0, brk0});
    end
    vec_cnt++;
    if ({dv1, byte1, pe1, fe1, brk1} !== 11'h000) begin
      err_cnt++;
      $display("FAIL reset_dut1: got %h expected 000", {dv1, byte1, pe1, fe1, brk1});
    end
    vec_cnt++;
    if ({dv2, byte2, pe2, fe2, brk2} !== 12'h000) begin
      err_cnt++;
      $display("FAIL reset_dut2: got %h expected 000", {dv2, byte2, pe2, fe2, brk2});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 1'b1, 4);
  endtask

  // 8N1 0xA5: DV lands after edge 3 + 43 + 9*87 = 829; the log holds cyc one later.
  task automatic test_latency_8n1();
    longint t0;
    q0.delete();
    c0.delete();
    t0 = cyc;
    send8n1(8'hA5);
    drive(0, 1'b1, 2 * C0);
    vec_cnt++;
    if (q0.size() != 1) begin
      err_cnt++;
      $display("FAIL a5_count: got %0d expected 1", q0.size());
    end else begin
      vec_cnt++;
      if (q0[0] !== {9'h0A5, 3'b000}) begin
        err_cnt++;
        $display("FAIL a5_frame: got %h expected %h", q0[0], {9'h0A5, 3'b000});
      end
      vec_cnt++;
      if (c0[0] - t0 != 64'd830) begin
        err_cnt++;
        $display("FAIL a5_latency: got edge %0d expected edge 829", c0[0] - t0 - 1);
      end
    end
  endtask

  // 0x35 = 0110101 has four ones, so even parity bit 0 is correct and 1 is wrong.
  task automatic test_parity();
    logic [6:0] d;
    d = 7'h35;
    q1.delete();
    for (int p = 0; p < 2; p++) begin
      drive(1, 1'b0, C1);
      for (int i = 0; i < 7; i++) drive(1, d[i], C1);
      drive(1, p[0], C1);
      drive(1, 1'b1, C1);
      drive(1, 1'b1, 2 * C1);
    end
    vec_cnt++;
    if (q1.size() != 2) begin
      err_cnt++;
      $display("FAIL parity_count: got %0d expected 2", q1.size());
    end else begin
      vec_cnt++;
      if (q1[0] !== {9'h035, 3'b000}) begin
        err_cnt++;
        $display("FAIL parity_good: got %h expected %h", q1[0], {9'h035, 3'b000});
      end
      vec_cnt++;
      if (q1[1] !== {9'h035, 3'b100}) begin
        err_cnt++;
        $display("FAIL parity_bad: got %h expected %h", q1[1], {9'h035, 3'b100});
      end
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] d;
    q2.delete();
    d = 8'h3C;
    drive(2, 1'b0, C2);
    for (int i = 0; i < 8; i++) drive(2, d[i], C2);
    drive(2, 1'b1, C2);
    drive(2, 1'b0, C2);
    drive(2, 1'b1, 3 * C2);
    d = 8'h81;
    drive(2, 1'b0, C2);
    for (int i = 0; i < 8; i++) drive(2, d[i], C2);
    drive(2, 1'b1, 2 * C2);
    drive(2, 1'b1, 2 * C2);
    vec_cnt++;
    if (q2.size() != 2) begin
      err_cnt++;
      $display("FAIL stop2_count: got %0d expected 2", q2.size());
    end else begin
      vec_cnt++;
      if (q2[0] !== {9'h03C, 3'b010}) begin
        err_cnt++;
        $display("FAIL stop2_bad: got %h expected %h", q2[0], {9'h03C, 3'b010});
      end
      vec_cnt++;
      if (q2[1] !== {9'h081, 3'b000}) begin
        err_cnt++;
        $display("FAIL stop2_next: got %h expected %h", q2[1], {9'h081, 3'b000});
      end
    end
  endtask

  task automatic test_break();
    q0.delete();
    drive(0, 1'b0, 30 * C0);
    vec_cnt++;
    if (q0.size() != 1) begin
      err_cnt++;
      $display("FAIL break_count_low: got %0d expected 1", q0.size());
    end else begin
      vec_cnt++;
      if (q0[0] !== {9'h000, 3'b011}) begin
        err_cnt++;
        $display("FAIL break_frame: got %h expected %h", q0[0], {9'h000, 3'b011});
      end
    end
    drive(0, 1'b1, 5 * C0);
    vec_cnt++;
    if (q0.size() != 1) begin
      err_cnt++;
      $display("FAIL break_count_high: got %0d expected 1", q0.size());
    end
  endtask

  // Start low for H-5 = 38 cycles: the start-bit sample sees high again.
  task automatic test_start_glitch();
    q0.delete();
    drive(0, 1'b0, 38);
    drive(0, 1'b1, 12 * C0);
    vec_cnt++;
    if (q0.size() != 0) begin
      err_cnt++;
      $display("FAIL start_glitch: got %0d frames expected 0", q0.size());
    end
  endtask

  // One-cycle low in data bit 3 of 0xFF, placed so the newest history entry is
  // the only low one when that bit is sampled.
  task automatic test_majority();
    q0.delete();
    drive(0, 1'b0, C0);
    for (int i = 0; i < 3; i++) drive(0, 1'b1, C0);
    drive(0, 1'b1, 43);
    drive(0, 1'b0, 1);
    drive(0, 1'b1, C0 - 44);
    for (int i = 4; i < 8; i++) drive(0, 1'b1, C0);
    drive(0, 1'b1, C0);
    drive(0, 1'b1, 2 * C0);
    vec_cnt++;
    if (q0.size() != 1) begin
      err_cnt++;
      $display("FAIL majority_count: got %0d expected 1", q0.size());
    end else begin
      vec_cnt++;
      if (q0[0] !== {9'h0FF, 3'b000}) begin
        err_cnt++;
        $display("FAIL majority_frame: got %h expected %h", q0[0], {9'h0FF, 3'b000});
      end
    end
  endtask

  task automatic test_reset_midframe();
    q0.delete();
    drive(0, 1'b0, C0);
    drive(0, 1'b1, C0);
    drive(0, 1'b0, C0);
    drive(0, 1'b1, 40);
    vec_cnt++;
    if (byte0[0] !== 1'b1) begin
      err_cnt++;
      $display("FAIL midframe_bit0: got %b expected 1", byte0[0]);
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({dv0, byte0, pe0, fe0, brk0} !== 12'h000) begin
      err_cnt++;
      $display("FAIL midframe_reset: got %h expected 000", {dv0, byte0, pe0, fe0, brk0});
    end
    rx0 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 1'b1, 12 * C0);
    vec_cnt++;
    if (q0.size() != 0) begin
      err_cnt++;
      $display("FAIL midframe_no_dv: got %0d frames expected 0", q0.size());
    end
    send8n1(8'h12);
    drive(0, 1'b1, 2 * C0);
    vec_cnt++;
    if (q0.size() != 1) begin
      err_cnt++;
      $display("FAIL after_reset_count: got %0d expected 1", q0.size());
    end else begin
      vec_cnt++;
      if (q0[0] !== {9'h012, 3'b000}) begin
        err_cnt++;
        $display("FAIL after_reset_frame: got %h expected %h", q0[0], {9'h012, 3'b000});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    q0.delete();
    for (int i = 0; i < 16; i++) begin
      v = 8'(i);
      send8n1(v);
    end
    drive(0, 1'b1, 2 * C0);
    vec_cnt++;
    if (q0.size() != 16) begin
      err_cnt++;
      $display("FAIL b2b_count: got %0d expected 16", q0.size());
    end
    for (int i = 0; i < 16; i++) begin
      if (i < q0.size()) begin
        vec_cnt++;
        if (q0[i] !== {9'(i), 3'b000}) begin
          err_cnt++;
          $display("FAIL b2b_frame%0d: got %h expected %h", i, q0[i], {9'(i), 3'b000});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency_8n1();
    test_parity();
    test_frame_err();
    test_break();
    test_start_glitch();
    test_majority();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
